// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: one-hot T0..T7 timing, registered opcode decode,
// halt and stop handling. Define TIMING_STEP_EN to add the step input and PAUSE state.
module timing_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] opcode,
`ifdef TIMING_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] t,
  output logic [3:0] q,
  output logic       busy,
  output logic       halted,
  output logic       instr_done
);

`ifdef TIMING_STEP_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT, PAUSE} state_t;
  logic step_prev;
`else
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`endif

  state_t     state, state_next;
  logic [7:0] t_next;
  logic [3:0] q_next;
  logic       stop_lat, stop_next;
  logic       end_cond, halt_cond;

  assign end_cond  = (q[1] & t[3]) | (q[2] & t[5]) | (q[3] & t[7]);
  assign halt_cond = q[0] & t[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= 8'd0;
      q        <= 4'd0;
      stop_lat <= 1'b0;
`ifdef TIMING_STEP_EN
      step_prev <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      t        <= t_next;
      q        <= q_next;
      stop_lat <= stop_next;
`ifdef TIMING_STEP_EN
      step_prev <= step;
`endif
    end
  end

  // A pending stop outranks the halt instruction: the sequencer always leaves to IDLE.
  always_comb begin
    state_next = state;
    t_next     = t;
    q_next     = q;
    stop_next  = stop_lat;
    instr_done = 1'b0;
    case (state)
      IDLE: begin
        t_next    = 8'd0;
        q_next    = 4'd0;
        stop_next = 1'b0;
        if (start && !stop) begin
          state_next = RUN;
          t_next     = 8'd1;
        end
      end
      RUN: begin
        stop_next = stop_lat | stop;
        if (end_cond || halt_cond) begin
          instr_done = 1'b1;
          q_next     = 4'd0;
          if (stop_lat || stop) begin
            state_next = IDLE;
            t_next     = 8'd0;
            stop_next  = 1'b0;
          end else if (halt_cond) begin
            state_next = HALT;
            t_next     = 8'd0;
          end else begin
`ifdef TIMING_STEP_EN
            state_next = PAUSE;
            t_next     = 8'd0;
`else
            t_next     = 8'd1;
`endif
          end
        end else if (t[7]) begin
          t_next = 8'd1;
          q_next = 4'd0;
        end else begin
          t_next = {t[6:0], 1'b0};
          if (t[2])
            q_next = 4'b0001 << opcode;
        end
      end
      HALT: begin
        t_next    = 8'd0;
        q_next    = 4'd0;
        stop_next = 1'b0;
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
          t_next     = 8'd1;
        end
      end
`ifdef TIMING_STEP_EN
      PAUSE: begin
        t_next    = 8'd0;
        q_next    = 4'd0;
        stop_next = 1'b0;
        if (stop) begin
          state_next = IDLE;
        end else if (step && !step_prev) begin
          state_next = RUN;
          t_next     = 8'd1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        t_next     = 8'd0;
        q_next     = 4'd0;
        stop_next  = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    halted = (state == HALT);
  end

endmodule
